symbol_histogram: RTL
=====================

SYMBOL_HISTOGRAM -- requirements
Module: symbol_histogram

Interface
REQ-001 SHALL have parameter S_WIDTH, default 8: symbol width for alphabet and text.
REQ-002 SHALL have parameter DEPTH, default 16, legal range 1..256: maximum alphabet entries.
REQ-003 SHALL have parameter CNT_WIDTH, default 8: width of every occurrence counter.
REQ-004 SHALL have derived width LW = $clog2(DEPTH+1).
REQ-005 SHALL have ports:
- clock  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a new job; sampled in IDLE only.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_symbol  in  S_WIDTH  alphabet symbol (LOAD) or text symbol (COUNT).
- in_last  in  1  last beat of the current phase.
- out_valid  out  1  dump beat valid.
- out_ready  in  1  downstream accepts the dump beat.
- out_symbol  out  S_WIDTH  alphabet entry symbol.
- out_count  out  CNT_WIDTH  occurrence count.
- out_miss  out  1  marks the trailer beat carrying the miss count.
- out_last  out  1  final dump beat.
- alph_len  out  LW  number of stored alphabet entries.
- busy  out  1  high when state != IDLE.
- done  out  1  one-cycle pulse when a job completes.
- sat_flag  out  1  sticky: a counter saturated during the job.
- alph_ovf  out  1  sticky: an alphabet beat was dropped because storage was full.

Function
REQ-006 SHALL implement FSM IDLE -> LOAD -> COUNT -> DUMP -> IDLE.
REQ-007 IDLE: in_ready=0, out_valid=0; start=1 -> LOAD next cycle; all counters, miss counter, alph_len, sat_flag, alph_ovf cleared on that edge.
REQ-008 start SHALL be ignored outside IDLE.
REQ-009 LOAD: in_ready=1; an accepted beat SHALL store in_symbol at index alph_len and increment alph_len, unless the symbol is already stored (dropped, no flag) or alph_len==DEPTH (dropped, alph_ovf set).
REQ-010 LOAD: an accepted beat with in_last=1 SHALL be processed per REQ-009, then move to COUNT.
REQ-011 COUNT: in_ready=1; an accepted beat SHALL increment the counter of the stored entry equal to in_symbol, otherwise the miss counter.
REQ-012 All counters SHALL saturate at 2^CNT_WIDTH-1; an increment attempted at that maximum sets sat_flag.
REQ-013 COUNT: an accepted beat with in_last=1 SHALL be counted, then move to DUMP.
REQ-014 Cycles with in_valid=0 SHALL change no storage, counter or state.
REQ-015 Throughput SHALL be one accepted beat per cycle in LOAD and COUNT.
REQ-016 DUMP: out_valid=1 from the first DUMP cycle; beats are entries 0..alph_len-1 (out_miss=0), then one trailer beat (out_miss=1, out_symbol=0, out_count=miss counter).
REQ-017 out_last=1 only on the trailer beat.
REQ-018 Beat index SHALL advance only on out_valid && out_ready; while out_ready=0, all out_* fields SHALL hold stable.
REQ-019 Trailer accepted -> IDLE, with done=1 for exactly that next cycle.
REQ-020 in_ready SHALL be 0 in DUMP; alph_len, sat_flag and alph_ovf SHALL hold their values until the next start.

Reset
REQ-021 reset=1 SHALL, on the next edge, force IDLE from any state (including mid-LOAD/COUNT/DUMP) and abandon the job.
REQ-022 reset=1 SHALL clear all entries and counters and drive every output to 0.
REQ-023 reset SHALL take priority over start, in_valid and out_ready in the same cycle.

Verification
REQ-024 Basic (DEPTH=4, CNT_WIDTH=4): alphabet 0x41,0x42,0x43(last); text 41,42,41,44,43,41(last) -> dump (41,3),(42,1),(43,1), then trailer miss=1 with out_last=1, then done pulse.
REQ-025 Duplicate/overflow: alphabet 1,2,1,3,4,5(last) -> stored 1,2,3,4; alph_len=4; alph_ovf=1.
REQ-026 Saturation: alphabet {7}; 20 text beats of 7 -> out_count=15, sat_flag=1, miss=0.
REQ-027 Backpressure/gaps: out_ready low 3 cycles mid-dump -> fields stable, no entry skipped or repeated; random in_valid gaps -> counts identical to gap-free run.
REQ-028 Reset mid-COUNT -> next cycle busy=0, all outputs 0; a following start job reports fresh counts only.

Source files
------------

// File: rtl/symbol_histogram.sv
// Alphabet-indexed symbol histogram: load an alphabet, count text symbols
// against it, then stream out per-entry counts followed by a miss-count trailer.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// LOAD  | accepting alphabet symbols into storage
// COUNT | accepting text symbols, bumping matching counters
// DUMP  | streaming entries 0..alph_len-1, then the miss trailer
module symbol_histogram #(
    parameter int S_WIDTH   = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 8,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [S_WIDTH-1:0]   in_symbol,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [S_WIDTH-1:0]   out_symbol,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_miss,
    output logic                 out_last,
    output logic [LW-1:0]        alph_len,
    output logic                 busy,
    output logic                 done,
    output logic                 sat_flag,
    output logic                 alph_ovf
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COUNT,
        ST_DUMP
    } state_t;

    state_t state_q, state_d;

    logic [S_WIDTH-1:0]   sym_mem [DEPTH];
    logic [CNT_WIDTH-1:0] cnt_mem [DEPTH];
    logic [CNT_WIDTH-1:0] miss_cnt;
    logic [LW-1:0]        dump_idx;
    logic                 hit;
    logic [IW-1:0]        hit_idx;
    logic                 trailer;

    assign trailer = (dump_idx == alph_len);
    assign busy    = (state_q != ST_IDLE);

    // Only entries below alph_len are live; stale slots never match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && (LW'(i) < alph_len) && (sym_mem[i] == in_symbol)) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_symbol = '0;
        out_count  = '0;
        out_miss   = 1'b0;
        out_last   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = ST_DUMP;
            end
            ST_DUMP: begin
                out_valid = 1'b1;
                if (trailer) begin
                    out_miss  = 1'b1;
                    out_last  = 1'b1;
                    out_count = miss_cnt;
                    if (out_ready) state_d = ST_IDLE;
                end else begin
                    out_symbol = sym_mem[dump_idx[IW-1:0]];
                    out_count  = cnt_mem[dump_idx[IW-1:0]];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                sym_mem[i] <= '0;
                cnt_mem[i] <= '0;
            end
            miss_cnt <= '0;
            alph_len <= '0;
            dump_idx <= '0;
            sat_flag <= 1'b0;
            alph_ovf <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < DEPTH; i++) cnt_mem[i] <= '0;
                        miss_cnt <= '0;
                        alph_len <= '0;
                        dump_idx <= '0;
                        sat_flag <= 1'b0;
                        alph_ovf <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid && !hit) begin
                        if (alph_len < LW'(DEPTH)) begin
                            sym_mem[alph_len[IW-1:0]] <= in_symbol;
                            alph_len <= alph_len + 1'b1;
                        end else begin
                            alph_ovf <= 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    if (in_valid) begin
                        if (hit) begin
                            if (cnt_mem[hit_idx] == CNT_MAX) sat_flag <= 1'b1;
                            else cnt_mem[hit_idx] <= cnt_mem[hit_idx] + 1'b1;
                        end else begin
                            if (miss_cnt == CNT_MAX) sat_flag <= 1'b1;
                            else miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (out_ready) begin
                        if (trailer) done <= 1'b1;
                        else dump_idx <= dump_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
